// File: rtl/fetch_pkg.sv
// ============================================================================
//  fetch_pkg
//  Shared types and defaults for the MIPS instruction-fetch stage.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc_p4;
    } if_id_t;

    // Plain 32-bit add: wraps 32'hFFFF_FFFC to zero.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_hold_buf.sv
// ============================================================================
//  fetch_hold_buf
//  One-entry skid buffer holding an acked instruction while IF/ID is stalled.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_hold_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc_p4,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc_p4
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_p4_q, pc_p4_d;

    // Clear wins so a redirect always drops a captured instruction.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_p4_d = pc_p4_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_p4_d = load_pc_p4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= 32'h0000_0000;
            pc_p4_q <= 32'h0000_0000;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_p4_q <= pc_p4_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc_p4 = pc_p4_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  fetch_stage
//  Owns the PC, fetches over a req/ack handshake and loads the IF/ID register.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_p4
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    if_id_t      if_id_q, if_id_d;

    logic        hb_load;
    logic        hb_clear;
    logic        hb_valid;
    logic [31:0] hb_instr;
    logic [31:0] hb_pc_p4;
    logic [31:0] pc_p4;

    assign pc_p4 = pc_inc(pc_q);

    fetch_hold_buf u_hold_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (hb_load),
        .clear      (hb_clear),
        .load_instr (imem_rdata),
        .load_pc_p4 (pc_p4),
        .valid      (hb_valid),
        .instr      (hb_instr),
        .pc_p4      (hb_pc_p4)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        if_id_d  = if_id_q;
        hb_load  = 1'b0;
        hb_clear = 1'b0;

        if (redirect) begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
            hb_clear      = 1'b1;
            if (state_q == DRAIN) begin
                target_d = branch_target;
            end else if (state_q == FETCH && !imem_ack) begin
                // The outstanding request must complete before the jump.
                target_d = branch_target;
                state_d  = DRAIN;
            end else begin
                pc_d    = branch_target;
                state_d = FETCH;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        if (stall) begin
                            hb_load = 1'b1;
                            state_d = HOLD;
                        end else begin
                            if_id_d = '{valid: 1'b1, instr: imem_rdata, pc_p4: pc_p4};
                            pc_d    = pc_p4;
                        end
                    end else if (!stall) begin
                        if_id_d.valid = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_d  = '{valid: hb_valid, instr: hb_instr, pc_p4: hb_pc_p4};
                        pc_d     = pc_p4;
                        hb_clear = 1'b1;
                        state_d  = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        pc_d    = target_q;
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            target_q <= 32'h0000_0000;
            if_id_q  <= '{valid: 1'b0, instr: NOP_INSTR, pc_p4: 32'h0000_0000};
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            if_id_q  <= if_id_d;
        end
    end

    // Request decodes straight from state so it drops the moment reset hits.
    assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign if_id_valid = if_id_q.valid;
    assign if_id_instr = if_id_q.instr;
    assign if_id_pc_p4 = if_id_q.pc_p4;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
//  tb_fetch_stage
//  Directed scoreboard bench for fetch_stage.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    typedef struct packed {
        logic        v;
        logic [31:0] instr;
        logic [31:0] p4;
        logic        chk_p4;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_p4;

    logic        w_req2;
    logic [31:0] w_addr2;
    logic [31:0] w_pc2;
    logic        w_v2;
    logic [31:0] w_instr2;
    logic [31:0] w_p42;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Memory returns its address as data.
    assign imem_rdata = imem_addr;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc_p4(if_id_pc_p4)
    );

    // Second instance for PC wrap, with a zero-wait memory.
    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .redirect(1'b0),
        .branch_target(32'h0), .imem_req(w_req2), .imem_addr(w_addr2),
        .imem_ack(w_req2), .imem_rdata(w_addr2), .pc(w_pc2),
        .if_id_valid(w_v2), .if_id_instr(w_instr2), .if_id_pc_p4(w_p42)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, " req"},   {31'd0, imem_req},    32'd0);
        chk({tag, " pc"},    pc,                   32'h0);
        chk({tag, " valid"}, {31'd0, if_id_valid}, 32'd0);
        chk({tag, " instr"}, if_id_instr,          32'h0);
        chk({tag, " pc_p4"}, if_id_pc_p4,          32'h0);
        chk({tag, " wrap pc"}, w_pc2,              32'hFFFF_FFFC);
    endtask

    // One clock: drive inputs, check the request, then check IF/ID and PC.
    task automatic step(input string tag, input logic s, input logic r, input logic a,
                        input logic [31:0] tgt, input logic ereq, input logic [31:0] eaddr,
                        input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                        input logic cp4, input logic [31:0] epc);
        exp_t e;
        stall = s; redirect = r; imem_ack = a; branch_target = tgt;
        sb.push_back('{v: ev, instr: ei, p4: ep, chk_p4: cp4, pc: epc});
        #1;
        chk({tag, " req"}, {31'd0, imem_req}, {31'd0, ereq});
        if (ereq) chk({tag, " addr"}, imem_addr, eaddr);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, " valid"}, {31'd0, if_id_valid}, {31'd0, e.v});
        chk({tag, " instr"}, if_id_instr, e.instr);
        if (e.chk_p4) chk({tag, " pc_p4"}, if_id_pc_p4, e.p4);
        chk({tag, " pc"}, pc, e.pc);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset_check("reset");
        rst_n = 1'b1;

        // tag, stall, redirect, ack, target, req, addr, valid, instr, pc_p4, chk_p4, pc
        step("idle",  0, 0, 0, 32'h0, 0, 32'h00, 0, 32'h00, 32'h00, 1, 32'h00);
        step("zw0",   0, 0, 1, 32'h0, 1, 32'h00, 1, 32'h00, 32'h04, 1, 32'h04);
        chk("wrap pc",    w_pc2,    32'h0);
        chk("wrap addr",  w_addr2,  32'h0);
        chk("wrap instr", w_instr2, 32'hFFFF_FFFC);
        chk("wrap pc_p4", w_p42,    32'h0);
        step("zw1",   0, 0, 1, 32'h0, 1, 32'h04, 1, 32'h04, 32'h08, 1, 32'h08);
        step("zw2",   0, 0, 1, 32'h0, 1, 32'h08, 1, 32'h08, 32'h0C, 1, 32'h0C);
        step("zw3",   0, 0, 1, 32'h0, 1, 32'h0C, 1, 32'h0C, 32'h10, 1, 32'h10);

        step("st0",   1, 0, 1, 32'h0, 1, 32'h10, 1, 32'h0C, 32'h10, 1, 32'h10);
        step("st1",   1, 0, 0, 32'h0, 0, 32'h10, 1, 32'h0C, 32'h10, 1, 32'h10);
        step("st2",   1, 0, 0, 32'h0, 0, 32'h10, 1, 32'h0C, 32'h10, 1, 32'h10);
        step("strel", 0, 0, 0, 32'h0, 0, 32'h10, 1, 32'h10, 32'h14, 1, 32'h14);

        step("lat0a", 0, 0, 0, 32'h0, 1, 32'h14, 0, 32'h10, 32'h14, 1, 32'h14);
        step("lat0b", 0, 0, 1, 32'h0, 1, 32'h14, 1, 32'h14, 32'h18, 1, 32'h18);
        step("lat1a", 0, 0, 0, 32'h0, 1, 32'h18, 0, 32'h14, 32'h18, 1, 32'h18);
        step("lat1b", 0, 0, 1, 32'h0, 1, 32'h18, 1, 32'h18, 32'h1C, 1, 32'h1C);
        step("zw4",   0, 0, 1, 32'h0, 1, 32'h1C, 1, 32'h1C, 32'h20, 1, 32'h20);

        step("rdr",   0, 1, 0, 32'h100, 1, 32'h20, 0, 32'h0, 32'h0, 0, 32'h20);
        step("drn0",  0, 0, 0, 32'h0,   1, 32'h20, 0, 32'h0, 32'h0, 0, 32'h20);
        step("drn1",  0, 0, 1, 32'h0,   1, 32'h20, 0, 32'h0, 32'h0, 0, 32'h100);
        step("tgt",   0, 0, 1, 32'h0,   1, 32'h100, 1, 32'h100, 32'h104, 1, 32'h104);

        step("hst",   1, 0, 1, 32'h0,   1, 32'h104, 1, 32'h100, 32'h104, 1, 32'h104);
        step("hrdr",  1, 1, 0, 32'h200, 0, 32'h0,   0, 32'h0,   32'h0,   0, 32'h200);
        step("tgt2",  0, 0, 1, 32'h0,   1, 32'h200, 1, 32'h200, 32'h204, 1, 32'h204);

        stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
        #1;
        chk("mid req",  {31'd0, imem_req}, 32'd1);
        chk("mid addr", imem_addr, 32'h204);
        #1;
        rst_n = 1'b0;
        #1;
        reset_check("async");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
